// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: turns one "load X, shift N left/right with fill F" command into per-cycle shift-register controls
//   clk, reset (sync, active-low), in_valid/in_ready handshake, in_data/in_dir/in_count/in_fill command fields,
//   abort; drives sr_select (0 right, 1 left, 2 load, 3 hold), sr_pdin, sr_l_in, sr_r_in; status busy, done, aborted
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_fill,
  input  logic             abort,
  output logic [1:0]       sr_select,
  output logic [WIDTH-1:0] sr_pdin,
  output logic             sr_l_in,
  output logic             sr_r_in,
  output logic             busy,
  output logic             done,
  output logic             aborted
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] data_n;
  logic dir, dir_n, fill, fill_n, ab_n;
  // sr_pdin doubles as the captured-data register; outputs are registered from the next state
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    data_n = sr_pdin;
    dir_n = dir;
    fill_n = fill;
    ab_n = 1'b0;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        state_n = LOAD;
        data_n = in_data;
        dir_n = in_dir;
        fill_n = in_fill;
        cnt_n = in_count > MAX_CNT ? MAX_CNT : in_count;
      end
      LOAD: begin
        ab_n = abort;
        state_n = (abort || cnt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        cnt_n = cnt - 1'b1;
        ab_n = abort;
        state_n = (abort || cnt == CNT_W'(1)) ? DONE : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      dir <= 1'b0;
      fill <= 1'b0;
      in_ready <= 1'b0;
      sr_select <= 2'd3;
      sr_pdin <= '0;
      sr_l_in <= 1'b0;
      sr_r_in <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dir <= dir_n;
      fill <= fill_n;
      in_ready <= state_n == IDLE;
      sr_select <= state_n == LOAD ? 2'd2 : state_n == SHIFT ? {1'b0, dir_n} : 2'd3;
      sr_pdin <= data_n;
      sr_l_in <= state_n == SHIFT && fill_n;
      sr_r_in <= state_n == SHIFT && fill_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      aborted <= ab_n;
    end
  end
endmodule

// File: tb/tb_usr_shift_sequencer.sv
// tb_usr_shift_sequencer: table-driven command vectors with a per-cycle expected-output scoreboard
module tb_usr_shift_sequencer;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_dir = 1'b0, in_fill = 1'b0, abort = 1'b0;
  logic [3:0] in_data = '0;
  logic [2:0] in_count = '0;
  logic in_ready, sr_l_in, sr_r_in, busy, done, aborted;
  logic [1:0] sr_select;
  logic [3:0] sr_pdin;
  always #5 clk = ~clk;
  usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dir(in_dir), .in_count(in_count), .in_fill(in_fill), .abort(abort),
    .sr_select(sr_select), .sr_pdin(sr_pdin), .sr_l_in(sr_l_in), .sr_r_in(sr_r_in),
    .busy(busy), .done(done), .aborted(aborted)
  );
  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] pdin;
    logic lin, rin, busy, done, ab, rdy;
  } out_t;
  typedef struct {
    logic [3:0] data;
    logic dir;
    logic [2:0] count;
    logic fill;
    int abort_cyc;
    logic [3:0] exp_model;
  } vec_t;
  out_t sbq[$];
  int n_chk = 0, n_fail = 0;
  logic [3:0] model = '0;
  function automatic out_t rec(input logic [1:0] sel, input logic [3:0] pdin, input logic lin, rin, bsy, dn, ab, rdy);
    return '{sel, pdin, lin, rin, bsy, dn, ab, rdy};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input out_t exp, input bit dc);
    out_t act, m;
    act = '{sr_select, sr_pdin, sr_l_in, sr_r_in, busy, done, aborted, in_ready};
    m = '1;
    if (dc) begin
      m.pdin = '0;
      m.ab = 1'b0;
    end
    n_chk++;
    if (((act ^ exp) & m) != '0) begin
      n_fail++;
      $display("FAIL %s: got sel=%0d pdin=%b l=%b r=%b busy=%b done=%b ab=%b rdy=%b, expected sel=%0d pdin=%b l=%b r=%b busy=%b done=%b ab=%b rdy=%b",
        name, act.sel, act.pdin, act.lin, act.rin, act.busy, act.done, act.ab, act.rdy,
        exp.sel, exp.pdin, exp.lin, exp.rin, exp.busy, exp.done, exp.ab, exp.rdy);
    end
  endtask
  task automatic model_upd();
    case (sr_select)
      2'd2: model = sr_pdin;
      2'd0: model = {sr_r_in, model[3:1]};
      2'd1: model = {model[2:0], sr_l_in};
      default: ;
    endcase
  endtask
  task automatic run_cmd(input vec_t v, input bit hold, input string tag);
    int n, k;
    bit ab;
    n = (v.count > 3'd4) ? 4 : int'(v.count);
    ab = v.abort_cyc > 0;
    k = ab ? v.abort_cyc - 1 : n;
    in_valid = 1'b1;
    in_data = v.data;
    in_dir = v.dir;
    in_count = v.count;
    in_fill = v.fill;
    abort = 1'b0;
    sbq.push_back(rec(2'd2, v.data, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < k; i++) sbq.push_back(rec({1'b0, v.dir}, v.data, v.fill, v.fill, 1'b1, 1'b0, 1'b0, 1'b0));
    sbq.push_back(rec(2'd3, v.data, 1'b0, 1'b0, 1'b1, 1'b1, ab, 1'b0));
    sbq.push_back(rec(2'd3, v.data, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step();
    for (int c = 1; c <= k + 3; c++) begin
      abort = (c == v.abort_cyc) || (c == k + 2);
      if (!hold) begin
        in_valid = (c <= k + 2) ? 1'($urandom) : 1'b0;
        in_data = 4'($urandom);
        in_count = 3'($urandom);
        in_dir = 1'($urandom);
        in_fill = 1'($urandom);
      end
      model_upd();
      chk($sformatf("%s c%0d", tag, c), sbq.pop_front(), c == k + 3);
      if (c <= k + 2) step();
    end
    abort = 1'b0;
    n_chk++;
    if (model !== v.exp_model) begin
      n_fail++;
      $display("FAIL %s model: got %b expected %b", tag, model, v.exp_model);
    end
  endtask
  initial begin
    vec_t tbl[8];
    tbl[0] = '{4'b1011, 1'b0, 3'd2, 1'b1, 0, 4'b1110};
    tbl[1] = '{4'b0111, 1'b1, 3'd3, 1'b0, 0, 4'b1000};
    tbl[2] = '{4'b1010, 1'b0, 3'd0, 1'b1, 0, 4'b1010};
    tbl[3] = '{4'b0110, 1'b1, 3'd7, 1'b1, 0, 4'b1111};
    tbl[4] = '{4'b1001, 1'b0, 3'd4, 1'b0, 3, 4'b0010};
    tbl[5] = '{4'b1111, 1'b0, 3'd5, 1'b0, 0, 4'b0000};
    tbl[6] = '{4'b1100, 1'b1, 3'd3, 1'b1, 1, 4'b1100};
    tbl[7] = '{4'b0101, 1'b1, 3'd1, 1'b0, 2, 4'b1010};
    in_valid = 1'b1;
    in_data = 4'hF;
    in_count = 3'd3;
    repeat (3) begin
      step();
      chk("reset", rec(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    end
    reset = 1'b1;
    step();
    chk("ready rise", rec(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) run_cmd(tbl[i], 1'b0, $sformatf("vec%0d", i));
    run_cmd('{4'b0011, 1'b0, 3'd1, 1'b0, 0, 4'b0001}, 1'b1, "hold1");
    run_cmd('{4'b1100, 1'b1, 3'd1, 1'b1, 0, 4'b1001}, 1'b1, "hold2");
    in_valid = 1'b0;
    in_data = 4'b1010;
    in_dir = 1'b0;
    in_count = 3'd4;
    in_fill = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rst_mid load", rec(2'd2, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    step();
    chk("rst_mid shift", rec(2'd0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    reset = 1'b0;
    step();
    chk("rst_mid reset", rec(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    reset = 1'b1;
    step();
    chk("rst_mid nodone1", rec(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    step();
    chk("rst_mid nodone2", rec(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    run_cmd(tbl[0], 1'b0, "recover");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
